// File: rtl/multiphase_buck_pwm.sv
// N-phase interleaved buck gate-drive generator.
// A shared master counter spaces the phase starts evenly across the period;
// each phase runs its own dead-time / on-time / freewheel sequence with an
// on-time clamp, a soft stop on disable and an immediate latched fault stop.
module multiphase_buck_pwm #(
    parameter int N_PHASE       = 4,
    parameter int PERIOD_CYCLES = 400,
    parameter int DEAD_TIME     = 10,
    parameter int CNT_W         = 16,
    parameter int TON_MAX       = 370
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic                       fault,
    input  logic                       fault_clr,
    input  logic [N_PHASE*CNT_W-1:0]   ton,
    output logic [2*N_PHASE-1:0]       gate,
    output logic [N_PHASE-1:0]         phase_start,
    output logic                       active,
    output logic                       fault_latched
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DT_RISE,
        S_HIGH,
        S_DT_FALL,
        S_LOW
    } phase_state_t;

    localparam int              SLOT     = PERIOD_CYCLES / N_PHASE;
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] DT_LOAD  = CNT_W'(DEAD_TIME - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TON_LIM  = CNT_W'(TON_MAX);

    logic [CNT_W-1:0] cnt;
    logic             run;
    logic             all_idle;
    logic             any_busy_nxt;
    logic [N_PHASE-1:0] start_hit;

    phase_state_t     state     [N_PHASE];
    phase_state_t     state_nxt [N_PHASE];
    logic [CNT_W-1:0] tmr         [N_PHASE];
    logic [CNT_W-1:0] tmr_nxt     [N_PHASE];
    logic [CNT_W-1:0] ton_eff     [N_PHASE];
    logic [CNT_W-1:0] ton_eff_nxt [N_PHASE];

    // Saturate a requested on-time to the largest value that still leaves
    // room for both dead times and a minimum freewheel interval.
    function automatic logic [CNT_W-1:0] clamp_ton(input logic [CNT_W-1:0] t);
        return (t > TON_LIM) ? TON_LIM : t;
    endfunction

    // Gate pair {upper,lower} driven in each phase state.
    function automatic logic [1:0] gate_decode(input phase_state_t s);
        case (s)
            S_HIGH:  return 2'b10;
            S_LOW:   return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    // Summarise phase activity for the run handshake and the active flag.
    always_comb begin
        all_idle     = 1'b1;
        any_busy_nxt = 1'b0;
        for (int k = 0; k < N_PHASE; k++) begin
            if (state[k] != S_IDLE)     all_idle     = 1'b0;
            if (state_nxt[k] != S_IDLE) any_busy_nxt = 1'b1;
        end
    end

    // Per-phase next state: fault beats a start, a start beats the stop rules.
    always_comb begin
        for (int k = 0; k < N_PHASE; k++) begin
            state_nxt[k]   = state[k];
            tmr_nxt[k]     = tmr[k];
            ton_eff_nxt[k] = ton_eff[k];
            start_hit[k]   = 1'b0;
            if (fault) begin
                state_nxt[k] = S_IDLE;
            end else if (run && cnt == CNT_W'(k * SLOT)) begin
                start_hit[k]   = 1'b1;
                ton_eff_nxt[k] = clamp_ton(ton[k*CNT_W +: CNT_W]);
                tmr_nxt[k]     = DT_LOAD;
                // A zero on-time skips the upper pulse and keeps freewheeling.
                state_nxt[k]   = (ton_eff_nxt[k] != '0) ? S_DT_RISE : S_LOW;
            end else begin
                case (state[k])
                    S_DT_RISE: begin
                        if (!run) begin
                            state_nxt[k] = S_IDLE;
                        end else if (tmr[k] == '0) begin
                            state_nxt[k] = S_HIGH;
                            tmr_nxt[k]   = ton_eff[k] - ONE;
                        end else begin
                            tmr_nxt[k]   = tmr[k] - ONE;
                        end
                    end
                    S_HIGH: begin
                        // Disable cuts the pulse short but keeps the dead time.
                        if (!run || tmr[k] == '0) begin
                            state_nxt[k] = S_DT_FALL;
                            tmr_nxt[k]   = DT_LOAD;
                        end else begin
                            tmr_nxt[k]   = tmr[k] - ONE;
                        end
                    end
                    S_DT_FALL: begin
                        if (tmr[k] == '0) begin
                            state_nxt[k] = S_LOW;
                            tmr_nxt[k]   = DT_LOAD;
                        end else begin
                            tmr_nxt[k]   = tmr[k] - ONE;
                        end
                    end
                    S_LOW: begin
                        // While running the timer is parked full so a stop
                        // always freewheels for a whole dead time.
                        if (run) begin
                            tmr_nxt[k]   = DT_LOAD;
                        end else if (tmr[k] == '0) begin
                            state_nxt[k] = S_IDLE;
                        end else begin
                            tmr_nxt[k]   = tmr[k] - ONE;
                        end
                    end
                    default: begin
                        state_nxt[k] = S_IDLE;
                    end
                endcase
            end
        end
    end

    // Control registers: run handshake, master counter, fault latch, phase
    // states and the registered gate/status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt           <= '0;
            run           <= 1'b0;
            fault_latched <= 1'b0;
            gate          <= '0;
            phase_start   <= '0;
            active        <= 1'b0;
            for (int k = 0; k < N_PHASE; k++) begin
                state[k] <= S_IDLE;
            end
        end else begin
            fault_latched <= fault | (fault_latched & ~fault_clr);
            run           <= !fault && enable && (run || (!fault_latched && all_idle));
            if (run) begin
                cnt <= (cnt == CNT_LAST) ? '0 : cnt + ONE;
            end else begin
                cnt <= '0;
            end
            phase_start <= start_hit;
            active      <= any_busy_nxt;
            for (int k = 0; k < N_PHASE; k++) begin
                state[k]         <= state_nxt[k];
                gate[2*k +: 2]   <= gate_decode(state_nxt[k]);
            end
        end
    end

    // Datapath registers: timers and sampled on-times need no reset because
    // they are always loaded before any state that reads them.
    always_ff @(posedge clk) begin
        for (int k = 0; k < N_PHASE; k++) begin
            tmr[k]     <= tmr_nxt[k];
            ton_eff[k] <= ton_eff_nxt[k];
        end
    end

endmodule

// File: tb/tb_multiphase_buck_pwm.sv
// Bench for multiphase_buck_pwm: a time-based reference model derived from
// start/stop/fault events plus directed scenarios with literal expectations.
module tb_multiphase_buck_pwm;

    localparam int NP    = 4;
    localparam int P     = 400;
    localparam int DT    = 10;
    localparam int CW    = 16;
    localparam int TM    = 370;
    localparam int SLOT  = P / NP;
    localparam int NEVER = 32'h3fff_ffff;

    logic              clk = 1'b0;
    logic              rst;
    logic              enable;
    logic              fault;
    logic              fault_clr;
    logic [NP*CW-1:0]  ton;
    logic [2*NP-1:0]   gate;
    logic [NP-1:0]     phase_start;
    logic              active;
    logic              fault_latched;

    multiphase_buck_pwm #(
        .N_PHASE(NP), .PERIOD_CYCLES(P), .DEAD_TIME(DT), .CNT_W(CW), .TON_MAX(TM)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .fault(fault), .fault_clr(fault_clr),
        .ton(ton), .gate(gate), .phase_start(phase_start), .active(active),
        .fault_latched(fault_latched)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int nc       = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at cycle %0d", name, act, exp, nc);
        end
    endtask

    // ---------------- reference model ----------------
    // Each phase is described by its start edge S, its clamped width w, an
    // optional stop edge X (with a flag for a cut-short upper pulse) and the
    // edge from which it is idle.
    int  e = 0;
    int  m_S [NP];
    int  m_w [NP];
    int  m_X [NP];
    bit  m_cut [NP];
    int  m_idle_from [NP];
    bit  m_run, m_fl;
    int  m_cnt;
    bit  model_ok = 1'b0;
    bit  run_pre, fl_pre, all_idle_pre;
    int  cnt_pre, dd, tk;
    logic [2*NP-1:0] exp_gate;
    logic [NP-1:0]   exp_ps;
    logic            exp_active, exp_fl;

    function automatic logic [1:0] seq_gate(input int d, input int w);
        if (w == 0)          return 2'b01;
        if (d < DT)          return 2'b00;
        if (d < DT + w)      return 2'b10;
        if (d < 2 * DT + w)  return 2'b00;
        return 2'b01;
    endfunction

    function automatic logic [1:0] phase_gate(input int k, input int ed);
        if (ed >= m_idle_from[k]) return 2'b00;
        if (m_cut[k] && ed >= m_X[k]) return (ed < m_X[k] + DT) ? 2'b00 : 2'b01;
        return seq_gate(ed - m_S[k], m_w[k]);
    endfunction

    always @(posedge clk) begin
        e++;
        if (rst) begin
            model_ok = 1'b1;
            m_run = 1'b0; m_fl = 1'b0; m_cnt = 0; exp_ps = '0;
            for (int k = 0; k < NP; k++) begin
                m_idle_from[k] = 0; m_X[k] = NEVER; m_cut[k] = 1'b0; m_S[k] = 0; m_w[k] = 0;
            end
        end else begin
            run_pre = m_run; fl_pre = m_fl; cnt_pre = m_cnt;
            all_idle_pre = 1'b1;
            for (int k = 0; k < NP; k++) if (e - 1 < m_idle_from[k]) all_idle_pre = 1'b0;
            exp_ps = '0;
            for (int k = 0; k < NP; k++) begin
                if (fault) begin
                    if (m_idle_from[k] > e) m_idle_from[k] = e;
                end else if (run_pre && cnt_pre == k * SLOT) begin
                    tk = int'(ton[k*CW +: CW]);
                    m_S[k] = e; m_w[k] = (tk > TM) ? TM : tk;
                    m_idle_from[k] = NEVER; m_X[k] = NEVER; m_cut[k] = 1'b0;
                    exp_ps[k] = 1'b1;
                end else if (!run_pre && (e - 1) < m_idle_from[k] && m_X[k] == NEVER) begin
                    m_X[k] = e;
                    dd = e - 1 - m_S[k];
                    if (m_w[k] == 0 || dd >= 2 * DT + m_w[k]) m_idle_from[k] = e + DT - 1;
                    else if (dd < DT)                         m_idle_from[k] = e;
                    else if (dd < DT + m_w[k]) begin
                        m_cut[k] = 1'b1; m_idle_from[k] = e + 2 * DT;
                    end else                                  m_idle_from[k] = m_S[k] + 3 * DT + m_w[k];
                end
            end
            m_run = !fault && enable && (run_pre || (!fl_pre && all_idle_pre));
            m_fl  = fault || (fl_pre && !fault_clr);
            m_cnt = run_pre ? ((cnt_pre == P - 1) ? 0 : cnt_pre + 1) : 0;
        end
        exp_active = 1'b0;
        for (int k = 0; k < NP; k++) begin
            exp_gate[2*k +: 2] = phase_gate(k, e);
            if (e < m_idle_from[k]) exp_active = 1'b1;
        end
        exp_fl = m_fl;
    end

    // ---------------- per-cycle compare and pulse monitor ----------------
    logic [NP-1:0] prev_up = '0, prev_lo = '0;
    int rise_t [NP], up_fall_t [NP], lo_fall_t [NP];
    int width [NP], gap_r [NP], gap_f [NP], period [NP];
    logic [31:0] ovl;

    always @(negedge clk) begin
        nc++;
        if (model_ok) begin
            chk("gate", 32'(gate), 32'(exp_gate));
            chk("phase_start", 32'(phase_start), 32'(exp_ps));
            chk("active", 32'(active), 32'(exp_active));
            chk("fault_latched", 32'(fault_latched), 32'(exp_fl));
            ovl = '0;
            for (int k = 0; k < NP; k++) if (gate[2*k+1] === 1'b1 && gate[2*k] === 1'b1) ovl = 32'd1;
            chk("gate_overlap", ovl, 32'd0);
        end
        for (int k = 0; k < NP; k++) begin
            if (gate[2*k+1] === 1'b1 && !prev_up[k]) begin
                period[k] = nc - rise_t[k]; rise_t[k] = nc; gap_r[k] = nc - lo_fall_t[k];
            end
            if (gate[2*k+1] !== 1'b1 && prev_up[k]) begin
                up_fall_t[k] = nc; width[k] = nc - rise_t[k];
            end
            if (gate[2*k] === 1'b1 && !prev_lo[k]) gap_f[k] = nc - up_fall_t[k];
            if (gate[2*k] !== 1'b1 && prev_lo[k])  lo_fall_t[k] = nc;
            prev_up[k] = (gate[2*k+1] === 1'b1);
            prev_lo[k] = (gate[2*k] === 1'b1);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    task automatic tick_to(input int t);
        while (nc < t) tick(1);
    endtask

    task automatic wait_upper(input int k, input logic lvl, input int lim, input string name);
        int n = 0;
        while (gate[2*k+1] !== lvl && n < lim) begin tick(1); n++; end
        if (n >= lim) chk(name, 32'(gate[2*k+1]), 32'(lvl));
    endtask

    task automatic wait_inactive(input int lim);
        int n = 0;
        while (active !== 1'b0 && n < lim) begin tick(1); n++; end
        chk("active_drops", 32'(active), 32'd0);
    endtask

    task automatic wait_ps(input int lim);
        int n = 0;
        do begin tick(1); n++; end while (phase_start === '0 && n < lim);
    endtask

    task automatic set_ton(input int t0, input int t1, input int t2, input int t3);
        ton[0*CW +: CW] = CW'(t0);
        ton[1*CW +: CW] = CW'(t1);
        ton[2*CW +: CW] = CW'(t2);
        ton[3*CW +: CW] = CW'(t3);
    endtask

    int n0, ns, ps_t, gaps;
    bit seen_low;

    initial begin
        rst = 1'b1; enable = 1'b0; fault = 1'b0; fault_clr = 1'b0;
        set_ton(100, 100, 100, 100);
        tick(3);
        chk("reset_gate", 32'(gate), 32'd0);
        chk("reset_phase_start", 32'(phase_start), 32'd0);
        chk("reset_active", 32'(active), 32'd0);
        chk("reset_fault_latched", 32'(fault_latched), 32'd0);
        rst = 1'b0;
        tick(3);

        // Basic run: staggered starts, 100-cycle pulses, 10-cycle dead gaps.
        enable = 1'b1; n0 = nc;
        tick_to(n0 + 2);
        chk("first_start_phase0", 32'(phase_start), 32'd1);
        for (int k = 0; k < NP; k++) begin
            tick_to(n0 + 11 + 100 * k);
            chk("upper_before_rise", 32'(gate[2*k+1]), 32'd0);
            tick(1);
            chk("upper_at_rise", 32'(gate[2*k+1]), 32'd1);
        end
        tick_to(n0 + 900);
        for (int k = 0; k < NP; k++) begin
            chk("basic_width", 32'(width[k]), 32'd100);
            chk("basic_gap_rise", 32'(gap_r[k]), 32'd10);
            chk("basic_gap_fall", 32'(gap_f[k]), 32'd10);
        end
        chk("basic_period", 32'(period[0]), 32'd400);

        // Soft stop while phase 1 is high.
        wait_upper(1, 1'b1, 600, "wait_phase1_high");
        ns = nc; enable = 1'b0;
        tick_to(ns + 1);  chk("stop_still_high", 32'(gate[3:2]), 32'd2);
        tick_to(ns + 2);  chk("stop_dt_start", 32'(gate[3:2]), 32'd0);
        tick_to(ns + 11); chk("stop_dt_end", 32'(gate[3:2]), 32'd0);
        tick_to(ns + 12); chk("stop_low_start", 32'(gate[3:2]), 32'd1);
        tick_to(ns + 21); chk("stop_low_end", 32'(gate[3:2]), 32'd1);
        tick_to(ns + 22); chk("stop_idle", 32'(gate[3:2]), 32'd0);
        wait_inactive(100);
        tick(5);

        // Clamp and zero on-time.
        set_ton(500, 0, 100, 100);
        enable = 1'b1; n0 = nc; gaps = 0; seen_low = 1'b0;
        while (nc < n0 + 900) begin
            tick(1);
            if (gate[3:2] == 2'b01) seen_low = 1'b1;
            if (seen_low && gate[3:2] == 2'b00) gaps++;
        end
        chk("clamp_width", 32'(width[0]), 32'd370);
        chk("clamp_gap_rise", 32'(gap_r[0]), 32'd10);
        chk("zero_ton_seen_low", 32'(seen_low), 32'd1);
        chk("zero_ton_no_gaps", 32'(gaps), 32'd0);
        enable = 1'b0;
        wait_inactive(100);
        tick(5);

        // On-time update while phase 2 is high.
        set_ton(100, 100, 50, 100);
        enable = 1'b1;
        wait_upper(2, 1'b1, 400, "wait_phase2_high");
        ton[2*CW +: CW] = CW'(150);
        wait_upper(2, 1'b0, 200, "wait_phase2_low");
        chk("update_old_width", 32'(width[2]), 32'd50);
        wait_ps(500);
        while (phase_start[2] !== 1'b1 && nc < n0 + 5000) wait_ps(500);
        chk("update_ps2", 32'(phase_start[2]), 32'd1);
        ps_t = nc;
        wait_upper(2, 1'b1, 100, "wait_phase2_high2");
        chk("update_rise_after_start", 32'(nc - ps_t), 32'd10);
        wait_upper(2, 1'b0, 300, "wait_phase2_low2");
        chk("update_new_width", 32'(width[2]), 32'd150);

        // Fault in the middle of a phase 0 pulse.
        wait_upper(0, 1'b1, 500, "wait_phase0_high");
        tick(20);
        fault = 1'b1; tick(1); fault = 1'b0;
        chk("fault_gates_off", 32'(gate), 32'd0);
        chk("fault_latched_set", 32'(fault_latched), 32'd1);
        tick(50);
        chk("fault_blocks_active", 32'(active), 32'd0);
        chk("fault_blocks_gate", 32'(gate), 32'd0);
        fault = 1'b1; fault_clr = 1'b1; tick(1); fault = 1'b0; fault_clr = 1'b0;
        chk("fault_beats_clear", 32'(fault_latched), 32'd1);
        tick(3);
        fault_clr = 1'b1; tick(1); fault_clr = 1'b0;
        chk("fault_cleared", 32'(fault_latched), 32'd0);
        wait_ps(50);
        chk("restart_phase0_first", 32'(phase_start), 32'd1);
        ps_t = nc;
        wait_ps(150);
        chk("restart_phase1_next", 32'(phase_start), 32'd2);
        chk("restart_stagger", 32'(nc - ps_t), 32'd100);

        // Reset in the middle of a pulse.
        wait_upper(0, 1'b1, 500, "wait_phase0_high_rst");
        tick(5);
        rst = 1'b1; tick(1);
        chk("rst_gate", 32'(gate), 32'd0);
        chk("rst_phase_start", 32'(phase_start), 32'd0);
        chk("rst_active", 32'(active), 32'd0);
        chk("rst_fault_latched", 32'(fault_latched), 32'd0);
        enable = 1'b0; rst = 1'b0;
        tick(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
